// File: rtl/vend_dispenser.sv
// Actuator sequencer for the newspaper vending FSM: turns each rising edge of R into
// a paper release followed by nickel/dime change pulses, one solenoid at a time.
module vend_dispenser #(
    parameter int PULSE_W    = 4,
    parameter int GAP_W      = 2,
    parameter int STOCK_INIT = 50,
    parameter int STOCK_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               R,
    input  logic               N1,
    input  logic               D1,
    input  logic               D2,
    input  logic               restock,
    output logic               latch_sol,
    output logic               nick_sol,
    output logic               dime_sol,
    output logic               busy,
    output logic               empty,
    output logic [STOCK_W-1:0] stock,
    output logic               overrun,
    output logic               soldout
);

    localparam int PMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W - 1);

    typedef enum logic [2:0] {IDLE, REL, NICK, DIME, GAP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        ph_q, ph_d;
    logic                 nick_q, nick_d;
    logic [1:0]           dime_q, dime_d;
    logic [STOCK_W-1:0]   stock_q, stock_d;
    logic                 r_prev_q, r_prev_d;
    logic                 sale_q, sale_d;
    logic                 cap_n1_q, cap_n1_d;
    logic [1:0]           cap_dime_q, cap_dime_d;
    logic                 overrun_q, overrun_d;
    logic                 soldout_q, soldout_d;
    logic                 latch_q, latch_d;
    logic                 nsol_q, nsol_d;
    logic                 dsol_q, dsol_d;
    logic                 busy_q, busy_d;

    // The sale and its change request are registered together, so the sequence starts one cycle later.
    always_comb begin
        r_prev_d   = R;
        sale_d     = R & ~r_prev_q;
        cap_n1_d   = N1;
        cap_dime_d = {1'b0, D1} + {D2, 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q + CW'(1);
        nick_d    = nick_q;
        dime_d    = dime_q;
        stock_d   = stock_q;
        overrun_d = overrun_q;
        soldout_d = soldout_q;
        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (sale_q) begin
                    nick_d = cap_n1_q;
                    dime_d = cap_dime_q;
                    if (stock_q != '0) begin
                        state_d = REL;
                        stock_d = stock_q - STOCK_W'(1);
                    end else begin
                        soldout_d = 1'b1;
                        if (cap_n1_q)                state_d = NICK;
                        else if (cap_dime_q != 2'd0) state_d = DIME;
                    end
                end
            end
            REL: begin
                if (ph_q == PULSE_LAST) begin
                    state_d = GAP;
                    ph_d    = '0;
                end
            end
            NICK: begin
                if (ph_q == PULSE_LAST) begin
                    state_d = GAP;
                    ph_d    = '0;
                    nick_d  = 1'b0;
                end
            end
            DIME: begin
                if (ph_q == PULSE_LAST) begin
                    state_d = GAP;
                    ph_d    = '0;
                    dime_d  = dime_q - 2'd1;
                end
            end
            GAP: begin
                if (ph_q == GAP_LAST) begin
                    ph_d = '0;
                    if (nick_q)              state_d = NICK;
                    else if (dime_q != 2'd0) state_d = DIME;
                    else                     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sale_q && (state_q != IDLE)) overrun_d = 1'b1;
        // Restock wins over a decrement in the same cycle.
        if (restock) stock_d = STOCK_W'(STOCK_INIT);
        latch_d = (state_d == REL);
        nsol_d  = (state_d == NICK);
        dsol_d  = (state_d == DIME);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            nick_q     <= 1'b0;
            dime_q     <= 2'd0;
            stock_q    <= STOCK_W'(STOCK_INIT);
            r_prev_q   <= 1'b1;
            sale_q     <= 1'b0;
            cap_n1_q   <= 1'b0;
            cap_dime_q <= 2'd0;
            overrun_q  <= 1'b0;
            soldout_q  <= 1'b0;
            latch_q    <= 1'b0;
            nsol_q     <= 1'b0;
            dsol_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            nick_q     <= nick_d;
            dime_q     <= dime_d;
            stock_q    <= stock_d;
            r_prev_q   <= r_prev_d;
            sale_q     <= sale_d;
            cap_n1_q   <= cap_n1_d;
            cap_dime_q <= cap_dime_d;
            overrun_q  <= overrun_d;
            soldout_q  <= soldout_d;
            latch_q    <= latch_d;
            nsol_q     <= nsol_d;
            dsol_q     <= dsol_d;
            busy_q     <= busy_d;
        end
    end

    assign latch_sol = latch_q;
    assign nick_sol  = nsol_q;
    assign dime_sol  = dsol_q;
    assign busy      = busy_q;
    assign stock     = stock_q;
    assign empty     = (stock_q == '0);
    assign overrun   = overrun_q;
    assign soldout   = soldout_q;

endmodule
